// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types, constants and helpers for the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef logic [31:0] addr_t;

  // Every instruction is one fixed-size word.
  localparam int INSN_BYTES = 4;

  // Force a fetch address onto an instruction boundary.
  function automatic addr_t align_pc(input addr_t a);
    return a & ~addr_t'(INSN_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_queue.sv
`default_nettype none
// ============================================================================
// Module   : pc_queue
// Brief    : Circular buffer with multi-entry write and read by count.
//            Writes and reads are prefixes of the lane vectors; the caller
//            guarantees counts never overflow or underflow the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pc_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [OCC_W-1:0] wr_count,
  input  logic [WIDTH-1:0] wr_data   [0:LANES-1],
  input  logic [OCC_W-1:0] rd_count,
  output logic             rd_valid  [0:LANES-1],
  output logic [WIDTH-1:0] rd_data   [0:LANES-1],
  output logic [OCC_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;

  // Storage array: no reset, stale entries are masked by occupancy.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int j = 0; j < LANES; j++) begin
        if (OCC_W'(j) < wr_count) begin
          r_mem[r_tail + PTR_W'(j)] <= wr_data[j];
        end
      end
    end
  end

  // Pointers wrap naturally; full vs empty is resolved by the occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PTR_W'(rd_count);
      r_tail <= r_tail + PTR_W'(wr_count);
      r_occ  <= r_occ - rd_count + wr_count;
    end
  end

  // Head-relative read lanes, zeroed when beyond the queued entries.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [PTR_W-1:0] w_idx;
      logic             w_valid;
      assign w_idx       = r_head + PTR_W'(i);
      assign w_valid     = OCC_W'(i) < r_occ;
      assign rd_valid[i] = w_valid;
      assign rd_data[i]  = w_valid ? r_mem[w_idx] : '0;
    end
  endgenerate

  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_n.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_n
// Brief    : N-wide sequential PC generator feeding a circular PC queue that
//            presents up to FETCH_WIDTH head entries to decode. A redirect
//            flushes the queue and restarts fetch at the aligned target.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_n
  import fetch_pkg::*;
#(
  parameter int    FETCH_WIDTH = 2,
  parameter int    DEPTH       = 8,
  parameter addr_t RESET_PC    = 32'h0000_0000,
  localparam int   CNT_W       = $clog2(FETCH_WIDTH + 1),
  localparam int   OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_enable,
  input  logic             redirect_valid,
  input  addr_t            redirect_pc,
  input  logic [CNT_W-1:0] deq_count,
  output logic             is_valid  [0:FETCH_WIDTH-1],
  output addr_t            pc        [0:FETCH_WIDTH-1],
  output logic [OCC_W-1:0] occupancy
);

  localparam logic [OCC_W-1:0] c_fw    = OCC_W'(FETCH_WIDTH);
  localparam logic [OCC_W-1:0] c_depth = OCC_W'(DEPTH);

  addr_t            r_fetch_pc;
  addr_t            w_wr_data [0:FETCH_WIDTH-1];
  logic [OCC_W-1:0] w_avail;
  logic [OCC_W-1:0] w_space;
  logic [OCC_W-1:0] w_deq_req;
  logic [OCC_W-1:0] w_d;
  logic [OCC_W-1:0] w_e;

  // Clamp dequeue to what is shown and enqueue to free space; redirect
  // suppresses both. Enqueue looks at pre-dequeue occupancy only, so no
  // path exists from deq_count to the write side.
  always_comb begin
    w_avail   = (occupancy < c_fw) ? occupancy : c_fw;
    w_space   = c_depth - occupancy;
    w_deq_req = OCC_W'(deq_count);
    w_d       = '0;
    w_e       = '0;
    if (!redirect_valid) begin
      w_d = (w_deq_req < w_avail) ? w_deq_req : w_avail;
      if (fetch_enable) begin
        w_e = (w_space < c_fw) ? w_space : c_fw;
      end
    end
  end

  // Sequential PCs for each write lane.
  generate
    for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_wr_data
      assign w_wr_data[j] = r_fetch_pc + addr_t'(INSN_BYTES * j);
    end
  endgenerate

  // Fetch address: restart at the aligned target on redirect, else advance
  // past the entries written this cycle (32-bit wrap is intentional).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= align_pc(redirect_pc);
    end else begin
      r_fetch_pc <= r_fetch_pc + addr_t'(w_e) * addr_t'(INSN_BYTES);
    end
  end

  pc_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(addr_t)),
    .LANES (FETCH_WIDTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .wr_count  (w_e),
    .wr_data   (w_wr_data),
    .rd_count  (w_d),
    .rd_valid  (is_valid),
    .rd_data   (pc),
    .occupancy (occupancy)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_n
// Brief    : Scoreboard bench for fetch_queue_n. A list-of-PCs reference
//            model is stepped on each rising edge and its expected outputs
//            are queued; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_n;

  localparam int          FW       = 2;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = $clog2(FW + 1);
  localparam int          OCC_W    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      occ;
    logic [FW-1:0]    v;
    logic [FW*32-1:0] pcs;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_enable;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] deq_count;
  logic             is_valid_o [0:FW-1];
  logic [31:0]      pc_o       [0:FW-1];
  logic [OCC_W-1:0] occupancy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_q [$];
  logic [31:0] m_fpc;
  exp_t        exp_q [$];

  fetch_queue_n #(
    .FETCH_WIDTH (FW),
    .DEPTH       (DEPTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_count      (deq_count),
    .is_valid       (is_valid_o),
    .pc             (pc_o),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the queue is a list of PCs; fetch appends, decode pops front.
  function automatic void model_step();
    int avail, d, e, room;
    if (!reset) begin
      model_q.delete();
      m_fpc = RESET_PC;
      return;
    end
    if (redirect_valid) begin
      model_q.delete();
      m_fpc = redirect_pc & 32'hFFFF_FFFC;
      return;
    end
    avail = (model_q.size() < FW) ? model_q.size() : FW;
    d     = (int'(deq_count) < avail) ? int'(deq_count) : avail;
    room  = DEPTH - model_q.size();
    e     = fetch_enable ? ((room < FW) ? room : FW) : 0;
    for (int k = 0; k < d; k++) void'(model_q.pop_front());
    for (int k = 0; k < e; k++) begin
      model_q.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
    end
  endfunction

  function automatic exp_t model_view();
    exp_t x;
    x.occ = model_q.size();
    for (int i = 0; i < FW; i++) begin
      x.v[i]           = (i < model_q.size());
      x.pcs[i*32 +: 32] = (i < model_q.size()) ? model_q[i] : 32'h0;
    end
    return x;
  endfunction

  // One clock: advance the model on the edge, queue its expectation, then
  // return a little after the edge so the caller can drive new inputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_view());
    #2;
  endtask

  task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc,
                       input logic [CNT_W-1:0] dq);
    fetch_enable   = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_count      = dq;
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("occupancy", 32'(occupancy), x.occ);
      for (int i = 0; i < FW; i++) begin
        chk($sformatf("valid%0d", i), 32'(is_valid_o[i]), 32'(x.v[i]));
        chk($sformatf("pc%0d", i), pc_o[i], x.pcs[i*32 +: 32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, '0);
    #1;
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_valid0", 32'(is_valid_o[0]), 32'd0);
    chk("reset_pc0", pc_o[0], 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Fill from reset with no decode.
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    repeat (4) tick();

    // Drain one per cycle from a full queue.
    drive(1'b1, 1'b0, 32'h0, 2'd1);
    repeat (6) tick();

    // Redirect on a full queue with a simultaneous dequeue request.
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 32'h0000_0103, 2'd2);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    repeat (2) tick();

    // Over-requested dequeue with a single entry at 0x20.
    drive(1'b1, 1'b1, 32'h0000_001C, 2'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd2);
    repeat (2) tick();

    // Sustained full-rate decode; pointers wrap several times.
    drive(1'b1, 1'b0, 32'h0, 2'd2);
    repeat (12) tick();

    // Fetch address wrap past 0xFFFF_FFFC.
    drive(1'b1, 1'b1, 32'hFFFF_FFF9, 2'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd1);
    repeat (5) tick();

    // Asynchronous reset mid-cycle with three entries queued.
    drive(1'b0, 1'b1, 32'h0000_0040, 2'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    #1;
    chk("pre_reset_occ", 32'(occupancy), 32'd3);
    reset = 1'b0;
    model_q.delete();
    m_fpc = RESET_PC;
    #1;
    chk("async_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < FW; i++) begin
      chk($sformatf("async_valid%0d", i), 32'(is_valid_o[i]), 32'd0);
      chk($sformatf("async_pc%0d", i), pc_o[i], 32'd0);
    end
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    repeat (3) tick();

    // Randomized traffic, including deq_count beyond the lane count.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), rpc,
            CNT_W'($urandom_range(0, 3)));
      tick();
    end

    drive(1'b0, 1'b0, 32'h0, '0);
    tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue_n.md
Name: fetch_queue_n

Overview:
- Parametrised N-wide instruction fetch front end.
- Each cycle it generates up to FETCH_WIDTH sequential PCs and buffers them in a DEPTH-entry circular PC queue.
- The queue presents up to FETCH_WIDTH head entries to decode, which consumes a prefix of them by count.
- A redirect from execute flushes the queue and restarts fetch at the target; the block sits between branch resolution and decode.

Parameters:
- FETCH_WIDTH, 2, PCs generated and lanes presented per cycle (>=1).
- DEPTH, 8, queue entries; power of two, DEPTH >= FETCH_WIDTH.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- fetch_enable  input  1  1 = generate new PCs this cycle.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  redirect target.
- deq_count  input  $clog2(FETCH_WIDTH+1)  lanes consumed by decode this cycle (prefix 0..deq_count-1).
- is_valid  output  1 x [FETCH_WIDTH]  lane i holds a valid PC (unpacked array).
- pc  output  32 x [FETCH_WIDTH]  PC of lane i (unpacked array).
- occupancy  output  $clog2(DEPTH+1)  entries currently queued.

Behaviour:
- Reset (asynchronous on reset==0, independent of clk):
  - fetch_pc=RESET_PC; head=tail=0; occupancy=0.
  - All is_valid=0; pc outputs=0.
  - Takes effect immediately, including mid-operation; queue contents are discarded.
- Outputs are pure functions of registered state (no combinational path from inputs):
  - avail = min(occupancy, FETCH_WIDTH).
  - is_valid[i] = (i < avail).
  - pc[i] = queue[(head+i) mod DEPTH] when valid, else 0.
- Dequeue:
  - d = min(deq_count, avail); excess deq_count is clamped silently.
  - head <= head + d (mod DEPTH).
- Enqueue:
  - e = fetch_enable ? min(FETCH_WIDTH, DEPTH - occupancy) : 0.
  - e uses pre-dequeue occupancy to avoid a deq->enq combinational path, so full + deq gives no enqueue that cycle.
  - Entries written: queue[(tail+j) mod DEPTH] = fetch_pc + 4*j, for j < e.
  - tail <= tail + e; fetch_pc <= fetch_pc + 4*e (32-bit wrap, 0xFFFF_FFFC+4 -> 0).
- occupancy <= occupancy - d + e; never exceeds DEPTH, never negative.
- Latency: a PC generated in cycle t is visible on the outputs in cycle t+1 at the earliest.
- Redirect (highest priority over enqueue and dequeue):
  - head=tail=0; occupancy=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00} (low bits forced to zero).
  - No enqueue or dequeue that cycle.
  - Outputs invalid the next cycle; target PCs appear the cycle after.
- Simultaneous redirect + fetch_enable + deq_count: redirect wins; deq is ignored (flushed entries are wrong-path).
- Pointer wrap: head/tail are $clog2(DEPTH) bits with natural wrap; full vs empty is distinguished by occupancy, not by pointers.
- Steady state with deq_count=FETCH_WIDTH and queue non-empty: sustains FETCH_WIDTH PCs/cycle only when DEPTH >= 2*FETCH_WIDTH (design note, not enforced).
- fetch_enable=0: no new PCs; dequeue proceeds normally.

Decomposition:
- Package fetch_pkg:
  - typedef logic [31:0] addr_t.
  - localparam INSN_BYTES=4.
  - function align_pc(addr_t) that clears bits [1:0].
- Sub-module pc_queue:
  - Parametrised circular buffer (DEPTH, WIDTH ports).
  - Multi-write/multi-read by count, flush input, occupancy output.
- fetch_queue_n owns fetch_pc, the e/d clamping and redirect priority.

Test Plan (FETCH_WIDTH=2, DEPTH=4, RESET_PC=0 unless stated):
1. Release reset, fetch_enable=1, deq_count=0 -> cycle1 enqueue 0x0,0x4; cycle2 is_valid=1,1, pc=0x0,0x4, occupancy=2; cycle3 occupancy=4, fetch_pc=0x10; later cycles no enqueue.
2. Full queue, deq_count=1 each cycle -> out pc advances 0x0,0x4 -> 0x4,0x8 -> …; enqueue resumes only once pre-dequeue occupancy<4; no PC skipped or duplicated.
3. Full queue, redirect_valid=1, redirect_pc=0x103, deq_count=2 -> next cycle occupancy=0, is_valid=0,0; following cycle pc=0x100,0x104.
4. occupancy=1 (pc 0x20), deq_count=2 -> d clamped to 1; next cycle shows newly fetched PCs, starting at the PC following the last enqueued entry.
5. Sustained deq_count=2, fetch_enable=1 for 12 cycles with DEPTH=4 -> pointers wrap several times; PC stream strictly contiguous (+4); occupancy never exceeds 4.
6. Assert reset low between clock edges while occupancy=3 -> is_valid all 0 and occupancy=0 immediately (before next edge); after release, first valid pc=RESET_PC.
